// File: rtl/reg_dst_scoreboard_if.sv
// Issue / hazard / write-back bundle for reg_dst_scoreboard.
// master = control unit side, slave = scoreboard side.
interface reg_dst_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [2:0]        select;
    logic [ADDR_W-1:0] in_rt;
    logic [ADDR_W-1:0] in_rd;
    logic [ADDR_W-1:0] in_rs;
    logic              issue;
    logic              issue_ready;
    logic              sel_err;
    logic [ADDR_W-1:0] dest_q;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic              hazard_a;
    logic              hazard_b;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_dest;
    logic              retire;
    logic [CNT_W-1:0]  pend_cnt;

    modport master (
        output select, in_rt, in_rd, in_rs, issue,
        output src_a, src_b, retire,
        input  issue_ready, sel_err, dest_q,
        input  hazard_a, hazard_b, wb_valid, wb_dest, pend_cnt
    );

    modport slave (
        input  select, in_rt, in_rd, in_rs, issue,
        input  src_a, src_b, retire,
        output issue_ready, sel_err, dest_q,
        output hazard_a, hazard_b, wb_valid, wb_dest, pend_cnt
    );
endinterface

// File: rtl/reg_dst_scoreboard.sv
// Write-destination select plus in-order outstanding-write FIFO
// with per-register pending counts for RAW hazard detection.
module reg_dst_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32,
    parameter int DEPTH  = 4,
    parameter int SP_REG = 29,
    parameter int RA_REG = 31
) (
    input logic                  clk,
    input logic                  reset,
    reg_dst_scoreboard_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] fifo [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic [CNT_W-1:0]  occ;
    logic [CNT_W-1:0]  cnt [NREGS];
    logic [ADDR_W-1:0] dest_q;
    logic              sel_err;

    logic [ADDR_W-1:0] dec_dest;
    logic              dec_ok;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [NREGS-1:0]  inc_vec;
    logic [NREGS-1:0]  dec_vec;

    // Decode the select code into a destination register index
    always_comb begin
        dec_dest = '0;
        dec_ok   = 1'b1;
        unique case (bus.select)
            3'b000:  dec_dest = bus.in_rt;
            3'b001:  dec_dest = ADDR_W'(SP_REG);
            3'b010:  dec_dest = ADDR_W'(RA_REG);
            3'b011:  dec_dest = bus.in_rd;
            3'b100:  dec_dest = bus.in_rs;
            default: dec_ok   = 1'b0;
        endcase
    end

    assign full  = (occ == CNT_W'(DEPTH));
    assign empty = (occ == '0);
    assign push  = bus.issue & ~full & dec_ok;
    assign pop   = bus.retire & ~empty;

    // Per-register increment/decrement requests; r0 never counts
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (push && dec_dest != '0) inc_vec[dec_dest] = 1'b1;
        if (pop && fifo[rp] != '0)  dec_vec[fifo[rp]] = 1'b1;
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else begin
            if (push) begin
                fifo[wp] <= dec_dest;
                wp       <= wp + PTR_W'(1);
            end
            if (pop) rp <= rp + PTR_W'(1);
            if (push && !pop)      occ <= occ + CNT_W'(1);
            else if (pop && !push) occ <= occ - CNT_W'(1);
        end
    end

    // Pending-write counts; same-register issue and retire cancel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (dec_vec[i] && !inc_vec[i])
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    // Last accepted destination and illegal-select pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_q  <= '0;
            sel_err <= 1'b0;
        end else begin
            if (push) dest_q <= dec_dest;
            sel_err <= bus.issue & ~full & ~dec_ok;
        end
    end

    assign bus.issue_ready = ~full;
    assign bus.wb_valid    = ~empty;
    assign bus.wb_dest     = fifo[rp];
    assign bus.pend_cnt    = occ;
    assign bus.dest_q      = dest_q;
    assign bus.sel_err     = sel_err;
    assign bus.hazard_a    = (cnt[bus.src_a] != '0);
    assign bus.hazard_b    = (cnt[bus.src_b] != '0);
endmodule

// File: tb/tb_reg_dst_scoreboard.sv
// Bench for reg_dst_scoreboard: queue-based reference model,
// directed scenarios with literal expectations, random traffic.
module tb_reg_dst_scoreboard;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    reg_dst_scoreboard_if #(.ADDR_W(5), .DEPTH(DEPTH)) bus ();

    reg_dst_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    int q[$];
    int m_dest_q = 0;
    bit m_sel_err = 1'b0;

    function automatic int pending(int r);
        int n = 0;
        if (r == 0) return 0;
        foreach (q[i]) if (q[i] == r) n++;
        return n;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      nm, act, exp, $time);
    endtask

    // Model update on each clock edge, cleared asynchronously
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_dest_q  = 0;
            m_sel_err = 1'b0;
        end else begin
            int  d;
            bit  legal, full, psh, pp;
            legal = 1'b1;
            d = 0;
            case (bus.select)
                3'd0: d = int'(bus.in_rt);
                3'd1: d = 29;
                3'd2: d = 31;
                3'd3: d = int'(bus.in_rd);
                3'd4: d = int'(bus.in_rs);
                default: legal = 1'b0;
            endcase
            full = (q.size() == DEPTH);
            psh  = bus.issue && !full && legal;
            pp   = bus.retire && q.size() > 0;
            m_sel_err = bus.issue && !full && !legal;
            if (pp) void'(q.pop_front());
            if (psh) begin
                q.push_back(d);
                m_dest_q = d;
            end
        end
    end

    // Compare every cycle against the model
    always @(negedge clk) begin
        if (!reset) begin
            chk("issue_ready", int'(bus.issue_ready),
                int'(q.size() != DEPTH));
            chk("wb_valid", int'(bus.wb_valid), int'(q.size() != 0));
            chk("pend_cnt", int'(bus.pend_cnt), q.size());
            chk("dest_q", int'(bus.dest_q), m_dest_q);
            chk("sel_err", int'(bus.sel_err), int'(m_sel_err));
            chk("hazard_a", int'(bus.hazard_a),
                int'(pending(int'(bus.src_a)) != 0));
            chk("hazard_b", int'(bus.hazard_b),
                int'(pending(int'(bus.src_b)) != 0));
            if (q.size() != 0)
                chk("wb_dest", int'(bus.wb_dest), q[0]);
        end
    end

    // Drive one cycle of inputs away from the edge, return at negedge
    task automatic go(input int sel, input int rt, input int rd,
                      input int rs, input bit iss, input bit ret,
                      input int sa, input int sb);
        #1;
        bus.select = 3'(sel);
        bus.in_rt  = 5'(rt);
        bus.in_rd  = 5'(rd);
        bus.in_rs  = 5'(rs);
        bus.issue  = iss;
        bus.retire = ret;
        bus.src_a  = 5'(sa);
        bus.src_b  = 5'(sb);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_issue_ready"}, int'(bus.issue_ready), 1);
        chk({tag, "_wb_valid"}, int'(bus.wb_valid), 0);
        chk({tag, "_wb_dest"}, int'(bus.wb_dest), 0);
        chk({tag, "_pend_cnt"}, int'(bus.pend_cnt), 0);
        chk({tag, "_dest_q"}, int'(bus.dest_q), 0);
        chk({tag, "_sel_err"}, int'(bus.sel_err), 0);
        chk({tag, "_hazard_a"}, int'(bus.hazard_a), 0);
        chk({tag, "_hazard_b"}, int'(bus.hazard_b), 0);
    endtask

    int regs[8] = '{0, 1, 2, 3, 5, 7, 29, 31};

    initial begin
        bus.select = '0; bus.in_rt = '0; bus.in_rd = '0; bus.in_rs = '0;
        bus.issue = 1'b0; bus.retire = 1'b0;
        bus.src_a = 5'd8; bus.src_b = 5'd9;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("rst");

        // Single rd issue
        go(3, 0, 8, 0, 1, 0, 8, 0);
        chk("t1_dest_q", int'(bus.dest_q), 8);
        chk("t1_wb_dest", int'(bus.wb_dest), 8);
        chk("t1_pend", int'(bus.pend_cnt), 1);
        chk("t1_haz_a", int'(bus.hazard_a), 1);
        go(0, 0, 0, 0, 0, 1, 8, 0);
        chk("t1_haz_clr", int'(bus.hazard_a), 0);

        // Fill to DEPTH, overflow issue ignored, drain in order
        go(1, 0, 0, 0, 1, 0, 0, 0);
        go(2, 0, 0, 0, 1, 0, 0, 0);
        go(0, 5, 0, 0, 1, 0, 0, 0);
        go(4, 0, 0, 3, 1, 0, 29, 31);
        chk("t2_pend", int'(bus.pend_cnt), 4);
        chk("t2_ready", int'(bus.issue_ready), 0);
        go(3, 0, 8, 0, 1, 0, 29, 31);
        chk("t2_full_pend", int'(bus.pend_cnt), 4);
        chk("t2_full_dq", int'(bus.dest_q), 3);
        chk("t2_wb0", int'(bus.wb_dest), 29);
        go(0, 0, 0, 0, 0, 1, 29, 31);
        chk("t2_wb1", int'(bus.wb_dest), 31);
        go(0, 0, 0, 0, 0, 1, 29, 31);
        chk("t2_wb2", int'(bus.wb_dest), 5);
        go(0, 0, 0, 0, 0, 1, 29, 31);
        chk("t2_wb3", int'(bus.wb_dest), 3);
        go(0, 0, 0, 0, 0, 1, 29, 31);
        chk("t2_empty", int'(bus.wb_valid), 0);
        chk("t2_haz_a", int'(bus.hazard_a), 0);
        chk("t2_haz_b", int'(bus.hazard_b), 0);

        // Two writes to r9
        go(3, 0, 9, 0, 1, 0, 9, 0);
        go(3, 0, 9, 0, 1, 0, 9, 0);
        go(0, 0, 0, 0, 0, 1, 9, 0);
        chk("t3_haz_kept", int'(bus.hazard_a), 1);
        go(0, 0, 0, 0, 0, 1, 9, 0);
        chk("t3_haz_clr", int'(bus.hazard_a), 0);

        // Illegal select
        go(6, 0, 12, 0, 1, 0, 0, 0);
        chk("t4_sel_err", int'(bus.sel_err), 1);
        chk("t4_pend", int'(bus.pend_cnt), 0);
        chk("t4_dq", int'(bus.dest_q), 9);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_pulse_end", int'(bus.sel_err), 0);

        // Issue and retire of r7 on the same edge
        go(3, 0, 7, 0, 1, 0, 7, 0);
        go(3, 0, 7, 0, 1, 1, 7, 0);
        chk("t5_pend", int'(bus.pend_cnt), 1);
        chk("t5_haz", int'(bus.hazard_a), 1);
        go(0, 0, 0, 0, 0, 1, 7, 0);
        chk("t5_haz_clr", int'(bus.hazard_a), 0);

        // r0 enqueued without hazard, then async reset mid-cycle
        go(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t6_pend", int'(bus.pend_cnt), 1);
        chk("t6_haz0", int'(bus.hazard_a), 0);
        go(3, 0, 4, 0, 1, 0, 4, 0);
        chk("t6_haz4", int'(bus.hazard_a), 1);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async");
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = ($urandom_range(0, 9) == 0) ?
                  int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            if ($urandom_range(0, 299) == 0) begin
                #3 reset = 1'b1;
                @(negedge clk);
                #1 reset = 1'b0;
                @(negedge clk);
            end
            go(sel, regs[$urandom_range(0, 7)], regs[$urandom_range(0, 7)],
               regs[$urandom_range(0, 7)], ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 9) < 5), regs[$urandom_range(0, 7)],
               regs[$urandom_range(0, 7)]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
